// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives instmem's word address and
// presents {pc, inst} to decode; handles stall replay and branch/jump redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_en,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      mem_addr,
    input  logic [31:0]      mem_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [31:0]      out_pc,
    output logic [CNT_W-1:0] fetch_count,
    output logic             dbg_state
);

    // Handshake: out_valid/out_pc/out_inst hold stable until out_ready is seen
    // high with out_valid (accept) or a redirect discards the presented word.
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           st_q, st_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q  <= IDLE;
            pc_q  <= RESET_PC;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

    // pc_d is also the address requested this cycle, so the read data lines up
    // with pc_q one cycle later in every branch of the priority.
    always_comb begin
        st_d  = st_q;
        pc_d  = pc_q;
        cnt_d = cnt_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[31:2], 2'b00};
            st_d = fetch_en ? RUN : IDLE;
        end else if (st_q == IDLE) begin
            if (fetch_en) st_d = RUN;
        end else if (out_ready) begin
            cnt_d = cnt_q + 1'b1;
            pc_d  = pc_q + 32'd4;
            st_d  = fetch_en ? RUN : IDLE;
        end
    end

    always_comb begin
        out_valid   = (st_q == RUN);
        out_pc      = pc_q;
        out_inst    = mem_inst;
        fetch_count = cnt_q;
        dbg_state   = st_q;
        // While reset is held the address must not follow redirect inputs.
        if (!rst) mem_addr = {2'b00, RESET_PC[31:2]};
        else      mem_addr = {2'b00, pc_d[31:2]};
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances (RESET_PC=0/CNT_W=32 and
// RESET_PC=0x100/CNT_W=4) share stimulus, each with its own registered instmem port.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        fetch_en, redirect_valid, out_ready;
    logic [31:0] redirect_pc;

    logic [31:0] addr_a, inst_a, opc_a, oinst_a;
    logic        oval_a, dbg_a;
    logic [31:0] cnt_a;
    logic [31:0] addr_b, inst_b, opc_b, oinst_b;
    logic        oval_b, dbg_b;
    logic [3:0]  cnt_b;

    logic [31:0] mem [0:255];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // instmem model: 1-cycle registered read, index by low address bits
    always @(posedge clk) begin
        inst_a <= mem[addr_a[7:0]];
        inst_b <= mem[addr_b[7:0]];
    end

    fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst_a), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_addr(addr_a), .mem_inst(inst_a), .out_valid(oval_a),
        .out_ready(out_ready), .out_inst(oinst_a), .out_pc(opc_a),
        .fetch_count(cnt_a), .dbg_state(dbg_a)
    );

    fetch_unit #(.RESET_PC(32'h0000_0100), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst_b), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_addr(addr_b), .mem_inst(inst_b), .out_valid(oval_b),
        .out_ready(out_ready), .out_inst(oinst_b), .out_pc(opc_b),
        .fetch_count(cnt_b), .dbg_state(dbg_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs are changed and outputs sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] inst, input logic [31:0] cnt);
        chk({tag, ".valid"}, 64'(oval_a), 64'(v));
        if (v) begin
            chk({tag, ".pc"},   64'(opc_a),   64'(pc));
            chk({tag, ".inst"}, 64'(oinst_a), 64'(inst));
        end
        chk({tag, ".cnt"}, 64'(cnt_a), 64'(cnt));
    endtask

    task automatic chk_b(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] inst, input logic [3:0] cnt);
        chk({tag, ".valid"}, 64'(oval_b), 64'(v));
        if (v) begin
            chk({tag, ".pc"},   64'(opc_b),   64'(pc));
            chk({tag, ".inst"}, 64'(oinst_b), 64'(inst));
        end
        chk({tag, ".cnt"}, 64'(cnt_b), 64'(cnt));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'(100 + i);
        rst_a = 1'b0; rst_b = 1'b0;
        fetch_en = 1'b1; out_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'h0;

        // reset state
        tick();
        chk("rst_a.valid", 64'(oval_a), 64'd0);
        chk("rst_a.pc",    64'(opc_a),  64'h0);
        chk("rst_a.addr",  64'(addr_a), 64'h0);
        chk("rst_a.cnt",   64'(cnt_a),  64'd0);
        chk("rst_b.addr",  64'(addr_b), 64'h40);
        chk("rst_b.pc",    64'(opc_b),  64'h100);

        // T1: streaming
        rst_a = 1'b1;
        #1 chk("t1.addr0", 64'(addr_a), 64'h0);
        tick(); chk_a("t1.c0", 1'b1, 32'h0, 32'd100, 32'd0);
        chk("t1.addr1", 64'(addr_a), 64'h1);
        tick(); chk_a("t1.c1", 1'b1, 32'h4, 32'd101, 32'd1);
        tick(); chk_a("t1.c2", 1'b1, 32'h8, 32'd102, 32'd2);

        // T2: stall at 0x8 for three cycles
        out_ready = 1'b0;
        #1 chk("t2.addr", 64'(addr_a), 64'h2);
        for (int k = 0; k < 3; k++) begin
            tick(); chk_a("t2.stall", 1'b1, 32'h8, 32'd102, 32'd2);
            chk("t2.addr_hold", 64'(addr_a), 64'h2);
        end
        out_ready = 1'b1;
        tick(); chk_a("t2.resume", 1'b1, 32'hC, 32'd103, 32'd3);

        // T3: stall at 0xC, then redirect to 0x43 with ready high (discarded)
        out_ready = 1'b0;
        tick(); chk_a("t3.stall", 1'b1, 32'hC, 32'd103, 32'd3);
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h43;
        #1 chk("t3.addr", 64'(addr_a), 64'h10);
        tick(); chk_a("t3.tgt", 1'b1, 32'h40, 32'd116, 32'd3);
        redirect_pc = 32'h10;
        tick(); chk_a("t3.tgt2", 1'b1, 32'h10, 32'd104, 32'd3);
        redirect_valid = 1'b0;

        // T4: accept 0x10 with fetch_en=0 -> drain to IDLE
        fetch_en = 1'b0;
        #1 chk("t4.addr", 64'(addr_a), 64'h5);
        tick(); chk_a("t4.idle", 1'b0, 32'h14, 32'd0, 32'd4);
        chk("t4.addr_idle", 64'(addr_a), 64'h5);
        chk("t4.dbg", 64'(dbg_a), 64'd0);
        tick(); chk_a("t4.idle2", 1'b0, 32'h14, 32'd0, 32'd4);
        fetch_en = 1'b1;
        tick(); chk_a("t4.run", 1'b1, 32'h14, 32'd105, 32'd4);
        // fetch_en low while stalled must not drop the presented word
        fetch_en = 1'b0; out_ready = 1'b0;
        tick(); chk_a("t4.hold", 1'b1, 32'h14, 32'd105, 32'd4);
        fetch_en = 1'b1; out_ready = 1'b1;
        tick(); chk_a("t4.next", 1'b1, 32'h18, 32'd106, 32'd5);

        // T5: instance B, RESET_PC=0x100, async reset mid-run
        rst_a = 1'b0; rst_b = 1'b1;
        tick(); chk_b("t5.c0", 1'b1, 32'h100, 32'd164, 4'd0);
        tick(); chk_b("t5.c1", 1'b1, 32'h104, 32'd165, 4'd1);
        tick(); chk_b("t5.c2", 1'b1, 32'h108, 32'd166, 4'd2);
        #2 rst_b = 1'b0;
        #1 chk("t5.rst_valid", 64'(oval_b), 64'd0);
        chk("t5.rst_cnt",  64'(cnt_b),  64'd0);
        chk("t5.rst_pc",   64'(opc_b),  64'h100);
        chk("t5.rst_addr", 64'(addr_b), 64'h40);
        tick(); rst_b = 1'b1;
        tick(); chk_b("t5.restart", 1'b1, 32'h100, 32'd164, 4'd0);

        // T6: PC wrap at 0xFFFF_FFFC and 4-bit counter wrap
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        #1 chk("t6.addr", 64'(addr_b), 64'h3FFF_FFFF);
        tick(); redirect_valid = 1'b0;
        chk_b("t6.top", 1'b1, 32'hFFFF_FFFC, 32'd355, 4'd0);
        tick(); chk_b("t6.wrap", 1'b1, 32'h0, 32'd100, 4'd1);
        for (int k = 2; k <= 16; k++) begin
            tick(); chk_b("t6.cnt", 1'b1, 32'(4 * (k - 1)), 32'(100 + k - 1), 4'(k));
        end
        chk("t6.cnt_zero", 64'(cnt_b), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
